// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants for the ripple-carry adder slice.
//
//   ADDER_WIDTH : default operand/sum width used by ripple_carry_adder_8bit.
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH = 8;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   One-bit combinational full adder; the building block of the ripple chain.
//
//   Ports
//     a, b : operand bits
//     cin  : carry in from the next-lower bit
//     s    : sum bit        = a ^ b ^ cin
//     cout : carry out      = majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/ripple_carry_adder_8bit.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder_8bit
//   Registered WIDTH-bit ripple-carry adder. The carry travels bit-serially
//   through a chain of full_adder cells; the sum, carry out and two's-complement
//   overflow are captured one cycle after the operands are presented with
//   in_valid high. Outputs hold between valid results.
//
//   Ports
//     clk       : clock, all state updates on the rising edge
//     rst       : asynchronous active-high reset, clears all outputs
//     in1, in2  : WIDTH-bit operands (unsigned or two's complement)
//     c_in      : carry into bit 0
//     in_valid  : operands are sampled on edges where this is high
//     sum       : registered sum bits
//     c_out     : registered carry out of the top bit
//     overflow  : registered two's-complement overflow flag
//     out_valid : high for exactly the cycle after a sampled operand set
// -----------------------------------------------------------------------------
module ripple_carry_adder_8bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    // Signed overflow occurs exactly when the carry into the sign bit differs
    // from the carry out of it.
    function automatic logic ovf_flag(input logic carry_into_msb,
                                      input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

    // Stage p0: combinational ripple chain, carry_p0[i] is the carry into bit i
    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    assign carry_p0[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (in1[i]),
            .b    (in2[i]),
            .cin  (carry_p0[i]),
            .s    (sum_p0[i]),
            .cout (carry_p0[i+1])
        );
    end

    // Stage p1: output registers; data only loads on a valid sample so that
    // the previous result stays visible through idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum      <= sum_p0;
                c_out    <= carry_p0[WIDTH];
                overflow <= ovf_flag(carry_p0[WIDTH-1], carry_p0[WIDTH]);
            end
        end
    end

endmodule : ripple_carry_adder_8bit

// File: tb/tb_ripple_carry_adder_8bit.sv
// -----------------------------------------------------------------------------
// tb_ripple_carry_adder_8bit
//   Scoreboard bench: every accepted operand set pushes its expected result;
//   on the following falling edge the result is popped and compared. Cycles
//   with nothing pending expect out_valid low and the data outputs unchanged.
// -----------------------------------------------------------------------------
module tb_ripple_carry_adder_8bit;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in1, in2;
    logic         c_in, in_valid;
    logic [W-1:0] sum;
    logic         c_out, overflow, out_valid;

    exp_t sb_q[$];
    exp_t held;
    int   n_checks = 0;
    int   n_err    = 0;

    ripple_carry_adder_8bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference result built from plain integer addition; overflow from the
    // operand/result sign relationship.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.o  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("sum",       32'(sum),       32'(e.s));
            chk("c_out",     32'(c_out),     32'(e.c));
            chk("overflow",  32'(overflow),  32'(e.o));
            held = e;
        end else begin
            chk("out_valid_idle", 32'(out_valid), 32'd0);
            chk("sum_hold",       32'(sum),       32'(held.s));
            chk("c_out_hold",     32'(c_out),     32'(held.c));
            chk("overflow_hold",  32'(overflow),  32'(held.o));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sum"},       32'(sum),       32'd0);
        chk({tag, "_c_out"},     32'(c_out),     32'd0);
        chk({tag, "_overflow"},  32'(overflow),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = v;
        in1      = a;
        in2      = b;
        c_in     = c;
    endtask

    // One cycle: check what the previous edge produced, then present new inputs.
    task automatic step_model(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        check_outputs();
        drive(v, a, b, c);
        if (v) sb_q.push_back(model(a, b, c));
    endtask

    task automatic step_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        @(negedge clk);
        check_outputs();
        drive(1'b1, a, b, c);
        e.s = es; e.c = ec; e.o = eo;
        sb_q.push_back(e);
    endtask

    task automatic step_idle();
        step_model(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst  = 1'b1;
        held = '0;
        drive(1'b0, '0, '0, 1'b0);
        #2;
        check_zero("reset");

        // Valid operands presented while reset is held must be discarded.
        @(negedge clk);
        drive(1'b1, 8'h55, 8'h22, 1'b1);
        @(negedge clk);
        check_zero("reset_edge");
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step_idle();
        step_idle();

        // Directed cases, including back-to-back c_in-only change.
        step_exp(8'h6D, 8'h4D, 1'b0, 8'hBA, 1'b0, 1'b1);
        step_exp(8'h6D, 8'h4D, 1'b1, 8'hBB, 1'b0, 1'b1);
        step_exp(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        step_exp(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        step_exp(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        step_exp(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        step_exp(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        step_idle();
        step_idle();

        // Asynchronous reset between edges clears everything immediately.
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        held = '0;
        @(negedge clk);
        drive(1'b1, 8'hA5, 8'h5A, 1'b1);
        @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        step_idle();
        step_idle();
        step_exp(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0);

        // Sweep every operand pair with a random carry-in, breaking the stream
        // with idle cycles so output hold behaviour is exercised throughout.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step_model(1'b1, 8'(a), 8'(b), 1'($urandom_range(1, 0)));
                if (((a * 256 + b) % 97) == 96) step_idle();
            end
        end
        step_idle();
        step_idle();

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ripple_carry_adder_8bit
